// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, then shifts one byte
// (LSB first, odd parity) on device clock falls and checks the device ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 1680,
    parameter int REQ_CYCLES     = 14,
    parameter int TIMEOUT_CYCLES = 210000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_drv,
    output logic       ps2_dat_drv
);

    localparam int FLT_W = $clog2(FILTER_LEN + 1);
    localparam logic [10:0] INH_LAST = 11'(INHIBIT_CYCLES - 1);
    localparam logic [10:0] REQ_LAST = 11'(REQ_CYCLES - 1);
    localparam logic [17:0] WD_LIM   = 18'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_INHIBIT  = 3'd1,
        S_REQ      = 3'd2,
        S_XFER     = 3'd3,
        S_WAITIDLE = 3'd4,
        S_ERR      = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic               clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic [FLT_W-1:0]   flt_cnt_q, flt_cnt_d;
    logic               filt_q, filt_d;
    logic               fall_evt_q, fall_evt_d;
    logic [10:0]        tmr_q, tmr_d;
    logic [17:0]        wdog_q, wdog_d;
    logic [3:0]         n_q, n_d;
    logic [7:0]         shift_q, shift_d;
    logic               par_q, par_d;
    logic               clk_drv_q, clk_drv_d;
    logic               dat_drv_q, dat_drv_d;
    logic               tx_ready_q, tx_ready_d;
    logic               tx_done_q, tx_done_d;
    logic               tx_error_q, tx_error_d;
    logic               busy_q, busy_d;
    logic               bit_drv;

    // State register, synchronisers, filter and registered outputs
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            state_q    <= S_IDLE;
            clk_s1_q   <= 1'b0;
            clk_s2_q   <= 1'b0;
            dat_s1_q   <= 1'b0;
            dat_s2_q   <= 1'b0;
            flt_cnt_q  <= '0;
            filt_q     <= 1'b0;
            fall_evt_q <= 1'b0;
            tmr_q      <= '0;
            wdog_q     <= '0;
            n_q        <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            clk_drv_q  <= 1'b0;
            dat_drv_q  <= 1'b0;
            tx_ready_q <= 1'b0;
            tx_done_q  <= 1'b0;
            tx_error_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_s1_q   <= ps2_clk_in;
            clk_s2_q   <= clk_s1_q;
            dat_s1_q   <= ps2_dat_in;
            dat_s2_q   <= dat_s1_q;
            flt_cnt_q  <= flt_cnt_d;
            filt_q     <= filt_d;
            fall_evt_q <= fall_evt_d;
            tmr_q      <= tmr_d;
            wdog_q     <= wdog_d;
            n_q        <= n_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            clk_drv_q  <= clk_drv_d;
            dat_drv_q  <= dat_drv_d;
            tx_ready_q <= tx_ready_d;
            tx_done_q  <= tx_done_d;
            tx_error_q <= tx_error_d;
            busy_q     <= busy_d;
        end
    end

    // Glitch filter: the level flips only after FILTER_LEN consecutive differing samples
    always_comb begin
        flt_cnt_d  = '0;
        filt_d     = filt_q;
        fall_evt_d = 1'b0;
        if (clk_s2_q != filt_q) begin
            if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
                filt_d     = clk_s2_q;
                fall_evt_d = filt_q;
            end else begin
                flt_cnt_d = flt_cnt_q + FLT_W'(1);
            end
        end
    end

    // Next-state and datapath counters
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        wdog_d  = wdog_q;
        n_d     = n_q;
        shift_d = shift_q;
        par_d   = par_q;
        case (state_q)
            S_IDLE: begin
                if (tx_valid && tx_ready_q) begin
                    shift_d = tx_data;
                    par_d   = ~^tx_data;
                    tmr_d   = '0;
                    state_d = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (tmr_q == INH_LAST) begin
                    tmr_d   = '0;
                    state_d = S_REQ;
                end else begin
                    tmr_d = tmr_q + 11'd1;
                end
            end
            S_REQ: begin
                if (tmr_q == REQ_LAST) begin
                    tmr_d   = '0;
                    n_d     = '0;
                    wdog_d  = '0;
                    state_d = S_XFER;
                end else begin
                    tmr_d = tmr_q + 11'd1;
                end
            end
            S_XFER: begin
                if (fall_evt_q) begin
                    wdog_d = '0;
                    n_d    = (n_q == 4'hF) ? n_q : n_q + 4'd1;
                    if (n_q == 4'd10) begin
                        state_d = dat_s2_q ? S_ERR : S_WAITIDLE;
                    end
                end else if (wdog_q == WD_LIM) begin
                    state_d = S_ERR;
                end else begin
                    wdog_d = wdog_q + 18'd1;
                end
            end
            S_WAITIDLE: begin
                if (filt_q && dat_s2_q) begin
                    state_d = S_IDLE;
                end else if (wdog_q == WD_LIM) begin
                    state_d = S_ERR;
                end else begin
                    wdog_d = wdog_q + 18'd1;
                end
            end
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Line value for the bit addressed by n; stop bit and beyond release the line
    always_comb begin
        bit_drv = 1'b0;
        if (n_q < 4'd8) begin
            bit_drv = ~shift_q[n_q[2:0]];
        end else if (n_q == 4'd8) begin
            bit_drv = ~par_q;
        end
    end

    // Outputs are decoded from the next state and registered, so pins never glitch
    always_comb begin
        clk_drv_d  = 1'b0;
        dat_drv_d  = 1'b0;
        tx_ready_d = 1'b0;
        tx_done_d  = 1'b0;
        tx_error_d = 1'b0;
        busy_d     = 1'b1;
        case (state_d)
            S_IDLE: begin
                tx_ready_d = 1'b1;
                busy_d     = 1'b0;
                tx_done_d  = (state_q == S_WAITIDLE);
            end
            S_INHIBIT: clk_drv_d = 1'b1;
            S_REQ: begin
                clk_drv_d = 1'b1;
                dat_drv_d = 1'b1;
            end
            // start bit stays on the line until the first device fall
            S_XFER: dat_drv_d = (state_q == S_XFER && fall_evt_q) ? bit_drv : dat_drv_q;
            S_ERR:  tx_error_d = 1'b1;
            default: ;
        endcase
    end

    assign tx_ready    = tx_ready_q;
    assign tx_done     = tx_done_q;
    assign tx_error    = tx_error_q;
    assign busy        = busy_q;
    assign ps2_clk_drv = clk_drv_q;
    assign ps2_dat_drv = dat_drv_q;

endmodule
